// File: rtl/stream_fifo.sv
// Elastic valid/ready FIFO for any DEPTH >= 2, with flush, almost-full/empty flags,
// occupancy count and a peak-occupancy watermark.
module stream_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    peak,
  input  logic             peak_clr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : gen_bad_depth
    $error("stream_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH > DEPTH) begin : gen_bad_af
    $error("stream_fifo: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH > DEPTH) begin : gen_bad_ae
    $error("stream_fifo: AE_THRESH must not exceed DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] peak_q, peak_d;

  logic full, empty, push, pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake outputs depend only on registered state.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data     = mem[rptr_q];
  assign count        = count_q;
  assign peak         = peak_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
    if (peak_clr) begin
      peak_d = count_d;
    end else begin
      peak_d = (count_d > peak_q) ? count_d : peak_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DEPTH=5): directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_stream_fifo;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned AF    = DEPTH - 1;
  localparam int unsigned AE    = 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready, peak_clr;
  logic             in_ready, out_valid, almost_full, almost_empty;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CW-1:0]    count, peak;

  stream_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .peak        (peak),
    .peak_clr    (peak_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: contents as a queue plus a watermark.
  logic [WIDTH-1:0] model_q [$];
  int unsigned      model_peak = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check_eq({tag, "_count"}, 32'(count), sz);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(sz < DEPTH));
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(sz > 0));
    check_eq({tag, "_afull"}, 32'(almost_full), 32'(sz >= AF));
    check_eq({tag, "_aempty"}, 32'(almost_empty), 32'(sz <= AE));
    check_eq({tag, "_peak"}, 32'(peak), model_peak);
    check_eq({tag, "_bound"}, 32'(count <= CW'(DEPTH)), 32'd1);
    if (sz > 0) check_eq({tag, "_data"}, 32'(out_data), 32'(model_q[0]));
  endtask

  // Called at a negedge: drive, take one edge, update model, check at next negedge.
  task automatic step(input string tag, input logic r, input logic f, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy, input logic pc);
    bit do_push, do_pop;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; peak_clr = pc;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_peak = 0;
    end else begin
      if (f) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
      end
      if (pc || model_q.size() > model_peak) model_peak = model_q.size();
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    peak_clr = 1'b0;
    @(negedge clk);
    step("reset", 1, 0, 0, 8'h00, 0, 0);
    check_eq("reset_peak0", 32'(peak), 32'd0);

    // 1: fill to full, then a sixth push is held off.
    for (int i = 0; i < 5; i++) step("t1_fill", 0, 0, 1, 8'(8'h11 + i), 0, 0);
    step("t1_blocked", 0, 0, 1, 8'hEE, 0, 0);
    check_eq("t1_full_ready", 32'(in_ready), 32'd0);
    check_eq("t1_peak5", 32'(peak), 32'd5);

    // 2: drain in order.
    for (int i = 0; i < 5; i++) step("t2_drain", 0, 0, 0, 8'h00, 1, 0);
    check_eq("t2_empty", 32'(out_valid), 32'd0);

    // 3: move pointers to 3, then wrap the write pointer.
    for (int i = 0; i < 3; i++) step("t3_push", 0, 0, 1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 3; i++) step("t3_pop", 0, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step("t3_wpush", 0, 0, 1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 4; i++) step("t3_wpop", 0, 0, 0, 8'h00, 1, 0);

    // 4: simultaneous push/pop at count 2 after clearing the watermark.
    step("t4_pclr", 0, 0, 0, 8'h00, 0, 1);
    check_eq("t4_peak_clr0", 32'(peak), 32'd0);
    step("t4_p0", 0, 0, 1, 8'h40, 0, 0);
    step("t4_p1", 0, 0, 1, 8'h41, 0, 0);
    for (int i = 0; i < 10; i++) step("t4_both", 0, 0, 1, 8'(8'h50 + i), 1, 0);
    check_eq("t4_count2", 32'(count), 32'd2);
    check_eq("t4_peak2", 32'(peak), 32'd2);

    // 5: flush at count 3 with push and pop requested.
    step("t5_p", 0, 0, 1, 8'h60, 0, 0);
    step("t5_flush", 0, 1, 1, 8'h61, 1, 0);
    check_eq("t5_count0", 32'(count), 32'd0);
    check_eq("t5_peak3", 32'(peak), 32'd3);
    step("t5_push5a", 0, 0, 1, 8'h5A, 0, 0);
    check_eq("t5_data5a", 32'(out_data), 32'h5A);

    // 6: reset beats flush and push; then peak_clr snaps to current count.
    for (int i = 0; i < 3; i++) step("t6_fill", 0, 0, 1, 8'(8'h70 + i), 0, 0);
    step("t6_rst", 1, 1, 1, 8'h77, 0, 0);
    check_eq("t6_rst_count", 32'(count), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) step("t6_fill5", 0, 0, 1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 3; i++) step("t6_drain", 0, 0, 0, 8'h00, 1, 0);
    step("t6_pclr", 0, 0, 0, 8'h00, 0, 1);
    check_eq("t6_peak2", 32'(peak), 32'd2);

    // Random traffic with occasional flush, peak_clr and reset.
    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(199) == 0), ($urandom_range(49) == 0),
           ($urandom_range(99) < 60), 8'($urandom), ($urandom_range(99) < 50),
           ($urandom_range(29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
